merge_sort_param: RTL and testbench
===================================

Name: merge_sort_param

Overview:
- Parametrised bottom-up iterative merge sorter; successor to the fixed-size sort FSM in the algorithm benchmark set.
- Accepts N elements of W bits on a packed bus and sorts them in a ping-pong buffer pair.
- Supports ascending/descending order per job and signed/unsigned compare by parameter.
- Returns the sorted vector with a one-cycle done pulse.
- Sits between a packed-vector producer and consumer using a start/done handshake.

Parameters:
- N, 16, element count; power of two, >= 2.
- W, 32, element width in bits.
- SIGNED_CMP, 0, 1 = two's-complement compare, 0 = unsigned.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_sort  in  1  job request; sampled only in IDLE.
- descend  in  1  order for the job: 0 ascending, 1 descending; sampled with start_sort.
- data_in  in  N*W  unsorted input; element i is data_in[i*W +: W]; sampled with start_sort.
- busy  out  1  high while a job is in progress.
- done_sort  out  1  one-cycle pulse when data_out is updated.
- data_out  out  N*W  sorted result; element 0 is first in the requested order.

Behaviour:
- Reset: state IDLE, busy=0, done_sort=0, data_out=0, all counters 0. Reset mid-job aborts the job with no done pulse.
- States are IDLE, MERGE and FINISH.
- IDLE:
  - On the edge where start_sort=1 (edge 0), load data_in into buffer A and latch descend.
  - Set run width w=1, base=0, output index k=0, and set busy=1.
  - Go to MERGE.
- MERGE: writes exactly one element per cycle from the source buffer into the destination buffer.
  - Left run is [base, base+w) and right run is [base+w, base+2w), tracked by indices li and ri.
  - Take the left element if the right run is exhausted, or if the left run is not exhausted and the right element does not strictly precede the left one.
  - Ties take the left element, so the sort is stable.
  - "Precedes" means less-than when ascending and greater-than when descending, using signed compare if SIGNED_CMP=1.
  - When k reaches base+2w-1, base advances by 2w.
  - When k reaches N-1 the pass ends:
    - w doubles and the source/destination roles swap;
    - base, k, li and ri reset.
  - After log2(N) passes, go to FINISH.
- Total MERGE cycles are N*log2(N); writes occur on edges 1 .. N*log2(N).
- FINISH (edge N*log2(N)+1):
  - data_out takes the final buffer (B if log2(N) is odd, else A);
  - done_sort=1 for this one cycle, busy=0, go to IDLE.
- Latency: done_sort is high exactly N*log2(N)+1 edges after the sampling edge.
  - N=8 gives 25; N=16 gives 65.
  - A back-to-back start is accepted on the cycle after done_sort.
- start_sort while busy is ignored. data_in and descend changes during a job have no effect.
- data_out holds its value until the next FINISH.
- Width rules:
  - All indices are $clog2(N)+1 bits, so run ends at N do not wrap.
  - The pass counter is $clog2($clog2(N))+1 bits.
  - Compare is exactly W bits with no extension beyond the sign.

Decomposition:
- Package merge_sort_pkg holds:
  - the state enum (IDLE, MERGE, FINISH);
  - the index-width localparam function;
  - the mode bit encodings.
- One sub-module, merge_sort_cmp, is combinational with inputs a, b, descend and output take_b (b strictly precedes a). It is parametrised by W and SIGNED_CMP.
- The top level owns the FSM, buffers and counters.

Test Plan:
- N=8, W=8, unsigned, ascending, input {5,3,7,1,6,2,8,4} -> data_out {1,2,3,4,5,6,7,8}; done_sort high exactly 25 edges after start; busy high for edges 1-24.
- Same input with descend=1 -> {8,7,6,5,4,3,2,1}.
- SIGNED_CMP=1, N=4, W=8, input {0x7F,0x80,0x00,0xFF}, ascending -> {0x80,0xFF,0x00,0x7F}. With SIGNED_CMP=0 -> {0x00,0x7F,0x80,0xFF}.
- Duplicates / stability, N=8, W=8, input {2,2,1,1,3,3,0,0} -> {0,0,1,1,2,2,3,3}; all-equal input is unchanged.
- start_sort re-asserted with new data at edge 10 of a job -> ignored; the result matches the first data and there is exactly one done pulse.
- rst at edge 12 mid-job -> next cycle busy=0, done_sort=0, data_out=0. A new start then completes normally in 25 edges.

Source files
------------

// File: rtl/merge_sort_pkg.sv
// Shared definitions for the merge sorter.
//   state_t         : sorter states (IDLE, MERGE, FINISH)
//   ORDER_*         : encodings of the descend input
//   CMP_*           : encodings of the SIGNED_CMP parameter
//   idx_w / pass_w  : widths of the element indices and of the pass counter
package merge_sort_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MERGE  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic ORDER_ASC    = 1'b0;
    localparam logic ORDER_DESC   = 1'b1;

    localparam logic CMP_UNSIGNED = 1'b0;
    localparam logic CMP_SIGNED   = 1'b1;

    // One bit wider than an element address so run ends equal to N stay representable.
    function automatic int idx_w(input int n);
        return $clog2(n) + 1;
    endfunction

    // Holds 0 .. log2(N) inclusive.
    function automatic int pass_w(input int n);
        return $clog2($clog2(n)) + 1;
    endfunction

endpackage

// File: rtl/merge_sort_cmp.sv
// Element comparator for the merge sorter.
//   a, b     : W-bit elements (a from the left run, b from the right run)
//   descend  : 0 ascending, 1 descending
//   take_b   : 1 when b strictly precedes a in the requested order
// Compare is exactly W bits; SIGNED_CMP selects two's-complement interpretation.
module merge_sort_cmp
    import merge_sort_pkg::*;
#(
    parameter int W          = 32,
    parameter int SIGNED_CMP = 0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         descend,
    output logic         take_b
);

    logic b_lt_a;
    logic b_gt_a;

    generate
        if (SIGNED_CMP == int'(CMP_SIGNED)) begin : g_signed
            logic signed [W-1:0] sa;
            logic signed [W-1:0] sb;
            assign sa     = a;
            assign sb     = b;
            assign b_lt_a = (sb < sa);
            assign b_gt_a = (sb > sa);
        end else begin : g_unsigned
            assign b_lt_a = (b < a);
            assign b_gt_a = (b > a);
        end
    endgenerate

    // Strict compare only: equal elements never move b ahead of a, keeping the sort stable.
    assign take_b = (descend == ORDER_DESC) ? b_gt_a : b_lt_a;

endmodule

// File: rtl/merge_sort_param.sv
// Bottom-up iterative merge sorter with a ping-pong buffer pair.
//   clk, rst     : clock, synchronous active-high reset
//   start_sort   : job request, sampled only in IDLE (with descend and data_in)
//   descend      : 0 ascending, 1 descending
//   data_in      : N packed W-bit elements, element i at [i*W +: W]
//   busy         : high while a job is in progress
//   done_sort    : one-cycle pulse when data_out is updated
//   data_out     : sorted result, element 0 first in the requested order
// One element is merged per cycle; a job takes N*log2(N) merge cycles plus one
// cycle to publish the result.
module merge_sort_param
    import merge_sort_pkg::*;
#(
    parameter int N          = 16,
    parameter int W          = 32,
    parameter int SIGNED_CMP = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_sort,
    input  logic           descend,
    input  logic [N*W-1:0] data_in,
    output logic           busy,
    output logic           done_sort,
    output logic [N*W-1:0] data_out
);

    localparam int IW    = idx_w(N);
    localparam int PW    = pass_w(N);
    localparam int LOG2N = $clog2(N);
    localparam int AW    = LOG2N;

    localparam logic [IW-1:0] LAST_K     = IW'(N - 1);
    localparam logic [PW-1:0] LAST_PASS  = PW'(LOG2N - 1);
    // Pass p reads A when p is even, so an odd pass count leaves the result in B.
    localparam bit            FINAL_IN_B = (LOG2N % 2) == 1;

    state_t state, state_nxt;

    logic [W-1:0]  buf_a [N];
    logic [W-1:0]  buf_b [N];

    logic          desc_q;
    logic          done_q;
    logic [IW-1:0] w, base, k, li, ri;
    logic [PW-1:0] pass;

    logic          src_is_a;
    logic [IW-1:0] two_w, left_end, right_end, run_last;
    logic          left_ok, right_ok, take_b, take_left;
    logic [AW-1:0] li_a, ri_a, k_a;
    logic [W-1:0]  left_val, right_val, merge_val;
    logic          pass_end, run_end, last_pass;

    assign src_is_a  = ~pass[0];
    assign two_w     = {w[IW-2:0], 1'b0};
    assign left_end  = base + w;
    assign right_end = base + two_w;
    assign run_last  = right_end - IW'(1);

    assign left_ok   = (li < left_end);
    assign right_ok  = (ri < right_end);

    // An exhausted right index may equal N; its value is then never selected,
    // so dropping the top bit for addressing is harmless.
    assign li_a      = li[AW-1:0];
    assign ri_a      = ri[AW-1:0];
    assign k_a       = k[AW-1:0];

    assign left_val  = src_is_a ? buf_a[li_a] : buf_b[li_a];
    assign right_val = src_is_a ? buf_a[ri_a] : buf_b[ri_a];

    merge_sort_cmp #(
        .W          (W),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_cmp (
        .a       (left_val),
        .b       (right_val),
        .descend (desc_q),
        .take_b  (take_b)
    );

    assign take_left = !right_ok || (left_ok && !take_b);
    assign merge_val = take_left ? left_val : right_val;

    assign pass_end  = (k == LAST_K);
    assign run_end   = (k == run_last);
    assign last_pass = (pass == LAST_PASS);

    assign busy      = (state != IDLE);
    assign done_sort = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_sort) state_nxt = MERGE;
            MERGE:   if (pass_end && last_pass) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control: counters, latched order, done pulse and the published result.
    always_ff @(posedge clk) begin
        if (rst) begin
            desc_q   <= 1'b0;
            done_q   <= 1'b0;
            w        <= '0;
            base     <= '0;
            k        <= '0;
            li       <= '0;
            ri       <= '0;
            pass     <= '0;
            data_out <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_sort) begin
                        desc_q <= descend;
                        w      <= IW'(1);
                        base   <= '0;
                        k      <= '0;
                        li     <= '0;
                        ri     <= IW'(1);
                        pass   <= '0;
                    end
                end
                MERGE: begin
                    if (pass_end) begin
                        w    <= two_w;
                        base <= '0;
                        k    <= '0;
                        li   <= '0;
                        ri   <= two_w;
                        pass <= pass + PW'(1);
                    end else if (run_end) begin
                        base <= right_end;
                        li   <= right_end;
                        ri   <= right_end + w;
                        k    <= k + IW'(1);
                    end else begin
                        k <= k + IW'(1);
                        if (take_left) li <= li + IW'(1);
                        else           ri <= ri + IW'(1);
                    end
                end
                FINISH: begin
                    done_q <= 1'b1;
                    for (int i = 0; i < N; i++) begin
                        data_out[i*W +: W] <= FINAL_IN_B ? buf_b[i] : buf_a[i];
                    end
                end
                default: ;
            endcase
        end
    end

    // Data: load into A on start, then write one merged element per MERGE cycle
    // into whichever buffer is not the source of the current pass.
    always_ff @(posedge clk) begin
        if (state == IDLE && start_sort) begin
            for (int i = 0; i < N; i++) begin
                buf_a[i] <= data_in[i*W +: W];
            end
        end else if (state == MERGE) begin
            if (src_is_a) buf_b[k_a] <= merge_val;
            else          buf_a[k_a] <= merge_val;
        end
    end

endmodule

// File: tb/tb_merge_sort_param.sv
// Self-checking bench for merge_sort_param: four instances cover
// N=8/W=8 unsigned, N=4/W=8 signed, N=4/W=8 unsigned and N=16/W=12 signed.
module tb_merge_sort_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic         start8, desc8, busy8, done8;
    logic [63:0]  din8, dout8;
    logic         start4s, desc4s, busy4s, done4s;
    logic [31:0]  din4s, dout4s;
    logic         start4u, desc4u, busy4u, done4u;
    logic [31:0]  din4u, dout4u;
    logic         start16, desc16, busy16, done16;
    logic [191:0] din16, dout16;

    merge_sort_param #(.N(8), .W(8), .SIGNED_CMP(0)) dut8 (
        .clk(clk), .rst(rst), .start_sort(start8), .descend(desc8), .data_in(din8),
        .busy(busy8), .done_sort(done8), .data_out(dout8));
    merge_sort_param #(.N(4), .W(8), .SIGNED_CMP(1)) dut4s (
        .clk(clk), .rst(rst), .start_sort(start4s), .descend(desc4s), .data_in(din4s),
        .busy(busy4s), .done_sort(done4s), .data_out(dout4s));
    merge_sort_param #(.N(4), .W(8), .SIGNED_CMP(0)) dut4u (
        .clk(clk), .rst(rst), .start_sort(start4u), .descend(desc4u), .data_in(din4u),
        .busy(busy4u), .done_sort(done4u), .data_out(dout4u));
    merge_sort_param #(.N(16), .W(12), .SIGNED_CMP(1)) dut16 (
        .clk(clk), .rst(rst), .start_sort(start16), .descend(desc16), .data_in(din16),
        .busy(busy16), .done_sort(done16), .data_out(dout16));

    int checks = 0;
    int errors = 0;

    logic [31:0] vin  [16];
    logic [31:0] vlit [16];

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {191'b0, obs}, {191'b0, exp});
    endtask

    function automatic int cfg_n(input int sel);
        case (sel)
            0: return 8;
            1, 2: return 4;
            default: return 16;
        endcase
    endfunction

    function automatic int cfg_w(input int sel);
        return (sel == 3) ? 12 : 8;
    endfunction

    function automatic bit cfg_s(input int sel);
        return (sel == 1 || sel == 3);
    endfunction

    // Numeric value of an element as the specification defines it.
    function automatic longint key(input logic [31:0] v, input int w, input bit s);
        longint x;
        x = longint'(v) & ((longint'(1) << w) - 1);
        if (s && x[w-1]) x = x - (longint'(1) << w);
        return x;
    endfunction

    function automatic logic [191:0] pack(input int sel, input logic [31:0] vals [16]);
        logic [191:0] r;
        int n, w;
        n = cfg_n(sel);
        w = cfg_w(sel);
        r = '0;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < w; b++)
                r[i*w + b] = vals[i][b];
        return r;
    endfunction

    // Reference: stable insertion sort on numeric keys.
    function automatic logic [191:0] model(input int sel, input logic [31:0] vals [16], input bit desc);
        logic [31:0] a [16];
        logic [31:0] t;
        int n, w, j;
        bit s;
        longint kx, ky;
        n = cfg_n(sel);
        w = cfg_w(sel);
        s = cfg_s(sel);
        a = vals;
        for (int i = 1; i < n; i++) begin
            j = i;
            while (j > 0) begin
                kx = key(a[j], w, s);
                ky = key(a[j-1], w, s);
                if (desc ? (kx > ky) : (kx < ky)) begin
                    t = a[j]; a[j] = a[j-1]; a[j-1] = t;
                    j--;
                end else begin
                    j = 0;
                end
            end
        end
        return pack(sel, a);
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0: return busy8;
            1: return busy4s;
            2: return busy4u;
            default: return busy16;
        endcase
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            0: return done8;
            1: return done4s;
            2: return done4u;
            default: return done16;
        endcase
    endfunction

    function automatic logic [191:0] get_out(input int sel);
        logic [191:0] r;
        r = '0;
        case (sel)
            0: r[63:0] = dout8;
            1: r[31:0] = dout4s;
            2: r[31:0] = dout4u;
            default: r = dout16;
        endcase
        return r;
    endfunction

    task automatic drive(input int sel, input logic st, input logic d, input logic [191:0] v);
        case (sel)
            0: begin start8 = st;  desc8 = d;  din8 = v[63:0];  end
            1: begin start4s = st; desc4s = d; din4s = v[31:0]; end
            2: begin start4u = st; desc4u = d; din4u = v[31:0]; end
            default: begin start16 = st; desc16 = d; din16 = v; end
        endcase
    endtask

    task automatic set_start(input int sel, input logic st);
        case (sel)
            0: start8 = st;
            1: start4s = st;
            2: start4u = st;
            default: start16 = st;
        endcase
    endtask

    // Runs one job. intr_edge re-asserts start with other data at that edge,
    // rst_edge aborts the job with reset at that edge, hold checks the result
    // and absence of further done pulses for that many cycles afterwards.
    task automatic run_job(input int sel, input string tag, input logic [31:0] vals [16],
                           input bit desc, input bit use_lit, input int intr_edge,
                           input int rst_edge, input int hold);
        logic [191:0] exp, prev;
        int n, lat, lat_exp;
        n       = cfg_n(sel);
        lat_exp = n * $clog2(n) + 1;
        exp     = model(sel, vals, desc);
        prev    = get_out(sel);
        lat     = -1;
        drive(sel, 1'b1, desc, pack(sel, vals));
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (cyc == intr_edge) drive(sel, 1'b1, ~desc, ~pack(sel, vals));
            if (cyc == rst_edge) rst = 1'b1;
            @(posedge clk); #1;
            if (cyc == intr_edge) set_start(sel, 1'b0);
            if (cyc == rst_edge) begin
                rst = 1'b0;
                chk1({tag, "/rst_busy"}, get_busy(sel), 1'b0);
                chk1({tag, "/rst_done"}, get_done(sel), 1'b0);
                chk({tag, "/rst_out"}, get_out(sel), '0);
                return;
            end
            if (get_done(sel)) begin
                lat = cyc;
                break;
            end
            chk1({tag, "/busy"}, get_busy(sel), 1'b1);
            chk({tag, "/out_held"}, get_out(sel), prev);
        end
        chk({tag, "/latency"}, 192'(lat), 192'(lat_exp));
        chk({tag, "/data"}, get_out(sel), exp);
        if (use_lit) chk({tag, "/literal"}, get_out(sel), pack(sel, vlit));
        chk1({tag, "/busy_at_done"}, get_busy(sel), 1'b0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk1({tag, "/done_pulse"}, get_done(sel), 1'b0);
            chk({tag, "/hold"}, get_out(sel), exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, '0);
        drive(1, 1'b0, 1'b0, '0);
        drive(2, 1'b0, 1'b0, '0);
        drive(3, 1'b0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk1("reset/busy8", busy8, 1'b0);
        chk1("reset/done8", done8, 1'b0);
        chk("reset/out8", get_out(0), '0);
        chk1("reset/busy16", busy16, 1'b0);
        chk("reset/out16", get_out(3), '0);
        rst = 1'b0;
        @(posedge clk); #1;

        vin  = '{5, 3, 7, 1, 6, 2, 8, 4, 0, 0, 0, 0, 0, 0, 0, 0};
        vlit = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0};
        run_job(0, "asc8", vin, 1'b0, 1'b1, -1, -1, 3);
        vlit = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        run_job(0, "desc8", vin, 1'b1, 1'b1, -1, -1, 2);

        vin  = '{32'h7F, 32'h80, 32'h00, 32'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vlit = '{32'h80, 32'hFF, 32'h00, 32'h7F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_job(1, "signed4", vin, 1'b0, 1'b1, -1, -1, 1);
        vlit = '{32'h00, 32'h7F, 32'h80, 32'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_job(2, "unsigned4", vin, 1'b0, 1'b1, -1, -1, 1);

        vin  = '{2, 2, 1, 1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vlit = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0};
        run_job(0, "dups8", vin, 1'b0, 1'b1, -1, -1, 0);
        vin  = '{9, 9, 9, 9, 9, 9, 9, 9, 0, 0, 0, 0, 0, 0, 0, 0};
        vlit = vin;
        run_job(0, "equal8", vin, 1'b1, 1'b1, -1, -1, 0);

        vin  = '{40, 10, 30, 20, 80, 60, 70, 50, 0, 0, 0, 0, 0, 0, 0, 0};
        vlit = '{10, 20, 30, 40, 50, 60, 70, 80, 0, 0, 0, 0, 0, 0, 0, 0};
        run_job(0, "restart_ignored", vin, 1'b0, 1'b1, 10, -1, 30);

        run_job(0, "rst_mid", vin, 1'b1, 1'b0, -1, 12, 0);
        vin  = '{5, 3, 7, 1, 6, 2, 8, 4, 0, 0, 0, 0, 0, 0, 0, 0};
        vlit = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0};
        run_job(0, "after_rst", vin, 1'b0, 1'b1, -1, -1, 1);

        // Back-to-back random jobs: each start is issued on the cycle after done.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 16; i++) vin[i] = $urandom_range(0, 15);
            run_job(0, "rnd8", vin, t[0], 1'b0, -1, -1, 0);
        end
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 16; i++) vin[i] = $urandom();
            run_job(1, "rnd4s", vin, t[0], 1'b0, -1, -1, 0);
            run_job(2, "rnd4u", vin, t[1], 1'b0, -1, -1, 0);
        end
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 16; i++) vin[i] = (t == 4) ? $urandom_range(4090, 4095) : $urandom();
            run_job(3, "rnd16", vin, t[0], 1'b0, -1, -1, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
